// File: rtl/dip_debounce.sv
// dip_debounce: multi-bit DIP switch debouncer for the trainer board.
// Each switch bit goes through a two-flop synchronizer, then an
// independent stability counter. A new level is accepted only after it
// has persisted for STABLE_CYCLES consecutive edges. Accepted changes
// produce registered per-bit rise/fall pulses and an aggregate change
// pulse. freeze holds the debounced state and restarts every count.
module dip_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dip_raw,
  input  logic             freeze,
  output logic [WIDTH-1:0] dip_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             change
);

  // Counter wide enough to hold STABLE_CYCLES; it never reaches that value
  // because acceptance happens at STABLE_CYCLES-1 and clears it.
  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] dip_q_next;

  // Two-flop synchronizer; keeps sampling even while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= dip_raw;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             q_next;

      // Per-bit stability decision: any agreement with dip_q, or freeze,
      // restarts the count; the STABLE_CYCLES-th disagreeing edge accepts.
      always_comb begin
        cnt_next = cnt_reg;
        q_next   = dip_q[gi];
        if (freeze) begin
          cnt_next = '0;
        end else if (s2_reg[gi] == dip_q[gi]) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          q_next   = s2_reg[gi];
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      // Per-bit stability counter.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign dip_q_next[gi] = q_next;
    end
  endgenerate

  // Debounced level plus edge pulses, all registered so events line up
  // with the cycle in which the new dip_q value is first visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dip_q  <= '0;
      rise   <= '0;
      fall   <= '0;
      change <= 1'b0;
    end else begin
      dip_q  <= dip_q_next;
      rise   <= dip_q_next & ~dip_q;
      fall   <= ~dip_q_next & dip_q;
      change <= |(dip_q_next ^ dip_q);
    end
  end

endmodule

// File: tb/tb_dip_debounce.sv
// tb_dip_debounce: directed scenarios plus randomized stimulus for
// dip_debounce (WIDTH=8, STABLE_CYCLES=4), checked every cycle against a
// history-window reference model.
module tb_dip_debounce;
  localparam int W = 8;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] dip_raw;
  logic         freeze;
  logic [W-1:0] dip_q;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         change;

  int n_tests;
  int n_fail;

  dip_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dip_raw (dip_raw),
    .freeze  (freeze),
    .dip_q   (dip_q),
    .rise    (rise),
    .fall    (fall),
    .change  (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted when, over the last S edges since
  // reset, freeze was low and the synchronized input (the raw sample from
  // two edges earlier) disagreed with the current debounced level.
  typedef struct {
    logic [W-1:0] seen;
    logic         frz;
  } win_t;

  logic [W-1:0] hist[$];
  win_t         win[$];
  logic [W-1:0] m_q;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    win.delete();
    m_q    = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_step(input logic [W-1:0] raw, input logic frz);
    logic [W-1:0] seen;
    logic [W-1:0] new_q;
    win_t         e;
    seen = (hist.size() >= 2) ? hist[0] : '0;
    hist.push_back(raw);
    if (hist.size() > 2) hist.delete(0);
    e.seen = seen;
    e.frz  = frz;
    win.push_back(e);
    if (win.size() > S) win.delete(0);
    new_q = m_q;
    if (win.size() == S) begin
      for (int b = 0; b < W; b++) begin
        bit ok;
        ok = 1'b1;
        for (int j = 0; j < S; j++) begin
          if (win[j].frz || (win[j].seen[b] == m_q[b])) ok = 1'b0;
        end
        if (ok) new_q[b] = ~m_q[b];
      end
    end
    m_rise = new_q & ~m_q;
    m_fall = m_q & ~new_q;
    m_q    = new_q;
  endtask

  // One clock of stimulus: drive at negedge, advance model at posedge,
  // compare at the following negedge.
  task automatic cycle(input logic [W-1:0] raw, input logic frz);
    dip_raw = raw;
    freeze  = frz;
    @(posedge clk);
    model_step(raw, frz);
    @(negedge clk);
    check("dip_q", dip_q, m_q);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("change", change, |(m_rise | m_fall));
  endtask

  // Asserts reset at a negedge, checks the immediate clear, holds it for
  // three edges and releases it at a negedge.
  task automatic apply_reset(input logic [W-1:0] raw);
    dip_raw = raw;
    freeze  = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_dip_q", dip_q, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_change", change, 0);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_q", dip_q, 0);
      check("rst_hold_ev", {rise, fall, change}, 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int chg_seen;
    logic [W-1:0] val;
    logic         frz;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    dip_raw = '0;
    freeze  = 1'b0;
    model_reset();
    @(negedge clk);

    // Power-up with switches at 0xA5: reported as rise events.
    apply_reset(8'hA5);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      cycle(8'hA5, 1'b0);
      if (lat == 99 && dip_q == 8'hA5) begin
        lat = i;
        check("pwr_rise", rise, 8'hA5);
        check("pwr_fall", fall, 8'h00);
        check("pwr_change", change, 1);
      end
    end
    check("pwr_latency", lat, 6);
    $display("[TB] power-up 0xA5 latency=%0d", lat);

    // Bounce on bit 0 from a settled 0x00.
    for (int i = 0; i < 12; i++) cycle(8'h00, 1'b0);
    check("pre_bounce_q", dip_q, 8'h00);
    cycle(8'h01, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h01, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h01, 1'b0);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      cycle(8'h01, 1'b0);
      if (lat == 99 && dip_q == 8'h01) begin
        lat = i;
        check("bounce_rise", rise, 8'h01);
      end
    end
    check("bounce_latency", lat, 5);
    $display("[TB] bounce bit0 latency=%0d", lat);

    // Falling high nibble from 0xFF.
    for (int i = 0; i < 12; i++) cycle(8'hFF, 1'b0);
    check("pre_fall_q", dip_q, 8'hFF);
    lat = 99;
    for (int i = 0; i <= 20; i++) begin
      cycle(8'h0F, 1'b0);
      if (lat == 99 && dip_q == 8'h0F) begin
        lat = i;
        check("nib_fall", fall, 8'hF0);
        check("nib_rise", rise, 8'h00);
      end
    end
    check("nib_latency", lat, 5);
    $display("[TB] 0xFF->0x0F latency=%0d", lat);

    // Freeze while the switches move, then release.
    for (int i = 0; i < 12; i++) cycle(8'h00, 1'b0);
    chg_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(8'h3C, 1'b1);
      if (change) chg_seen++;
    end
    check("frz_hold_q", dip_q, 8'h00);
    check("frz_no_events", chg_seen, 0);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      cycle(8'h3C, 1'b0);
      if (lat == 99 && dip_q == 8'h3C) begin
        lat = i;
        check("frz_rise", rise, 8'h3C);
      end
    end
    check("frz_latency", lat, 4);
    $display("[TB] freeze release latency=%0d", lat);

    // Reset in the middle of a bit-7 count, then re-acceptance.
    for (int i = 0; i < 12; i++) cycle(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(8'h80, 1'b0);
    check("mid_q", dip_q, 8'h00);
    apply_reset(8'h80);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      cycle(8'h80, 1'b0);
      if (lat == 99 && dip_q == 8'h80) begin
        lat = i;
        check("mid_rise", rise, 8'h80);
      end
    end
    check("mid_latency", lat, 6);
    $display("[TB] reset mid-count re-accept latency=%0d", lat);

    // Bit 2 toggling every cycle never gets through.
    for (int i = 0; i < 12; i++) cycle(8'h00, 1'b0);
    chg_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle((i % 2 == 1) ? 8'h04 : 8'h00, 1'b0);
      if (change) chg_seen++;
    end
    check("tog_q", dip_q, 8'h00);
    check("tog_no_change", chg_seen, 0);
    $display("[TB] toggle bit2 changes=%0d", chg_seen);

    // Randomized holds of random lengths with occasional freeze stretches.
    for (int t = 0; t < 400; t++) begin
      int hold;
      val  = W'($urandom);
      frz  = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) cycle(val, frz);
    end
    $display("[TB] random phase done, dip_q=%0h", dip_q);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
